// File: rtl/fifo_anyread_pkg.sv
// Shared types and helpers for the any-count FIFO write-side arbiter.
package fifo_anyread_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    // A source may claim more words than one beat can carry; cap at the beat size.
    function automatic int unsigned clamp_cnt(input int unsigned cnt, input int unsigned max_cnt);
        return (cnt > max_cnt) ? max_cnt : cnt;
    endfunction

endpackage

// File: rtl/fifo_anyread_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after the start index.
module rr_pick #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] start,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 found
);

    // Scan offsets from farthest to nearest so the nearest request overwrites;
    // the index wraps explicitly so non-power-of-2 NUM_REQ works.
    always_comb begin
        int                   j;
        logic [IDX_WIDTH-1:0] jj;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(start) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            jj = IDX_WIDTH'(j);
            if (req[jj]) begin
                idx   = jj;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_anyread_wr_arb.sv
// Packet-granular round-robin arbiter sharing the FIFO's variable-width write port.
module fifo_anyread_wr_arb
    import fifo_anyread_pkg::*;
#(
    parameter int NUM_REQ            = 4,
    parameter int WORD_WIDTH         = 8,
    parameter int WORD_CNT_PER_WRITE = 4,
    parameter int WRITE_WIDTH        = $clog2(WORD_CNT_PER_WRITE + 1),
    parameter int IDX_WIDTH          = $clog2(NUM_REQ)
) (
    input  logic                                                  clk_i,
    input  logic                                                  rstn_i,
    input  logic                                                  flush_i,
    input  logic [NUM_REQ-1:0]                                    req_valid_i,
    input  logic [NUM_REQ-1:0][WRITE_WIDTH-1:0]                   req_cnt_i,
    input  logic [NUM_REQ-1:0][WORD_CNT_PER_WRITE-1:0][WORD_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]                                    req_last_i,
    output logic [NUM_REQ-1:0]                                    req_ready_o,
    output logic [WRITE_WIDTH-1:0]                                fifo_write_o,
    output logic [WORD_CNT_PER_WRITE-1:0][WORD_WIDTH-1:0]         fifo_data_o,
    output logic                                                  fifo_flush_o,
    input  logic                                                  fifo_ready_i,
    output logic [IDX_WIDTH-1:0]                                  grant_o,
    output logic                                                  grant_vld_o,
    output logic                                                  locked_o
);

    arb_state_e           state, state_nxt;
    logic [IDX_WIDTH-1:0] owner, owner_nxt;
    logic [IDX_WIDTH-1:0] rr_ptr, rr_ptr_nxt;
    logic [IDX_WIDTH-1:0] pick_idx;
    logic                 pick_found;
    logic [IDX_WIDTH-1:0] grant;
    logic                 grant_vld;
    logic                 accept;
    logic [IDX_WIDTH-1:0] grant_inc;

    rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .req   (req_valid_i),
        .start (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // State register: FSM state, lock owner and round-robin pointer.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state  <= ARB_IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // Next state: lock on a non-last beat, release and advance priority on last.
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        grant_inc  = (grant == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        if (flush_i) begin
            state_nxt  = ARB_IDLE;
            owner_nxt  = '0;
            rr_ptr_nxt = '0;
        end else if (accept) begin
            if (req_last_i[grant]) begin
                state_nxt  = ARB_IDLE;
                rr_ptr_nxt = grant_inc;
            end else begin
                state_nxt = ARB_LOCK;
                owner_nxt = grant;
            end
        end
    end

    // Outputs: grant selection and the zero-latency request-to-FIFO mux.
    always_comb begin
        if (state == ARB_LOCK) begin
            grant     = owner;
            grant_vld = req_valid_i[owner];
        end else begin
            grant     = pick_idx;
            grant_vld = pick_found;
        end
        accept       = grant_vld & fifo_ready_i & ~flush_i;
        req_ready_o  = '0;
        fifo_write_o = '0;
        fifo_data_o  = '0;
        if (accept) begin
            req_ready_o[grant] = 1'b1;
            fifo_write_o = WRITE_WIDTH'(clamp_cnt(32'(req_cnt_i[grant]),
                                                  32'(WORD_CNT_PER_WRITE)));
            fifo_data_o  = req_data_i[grant];
        end
        fifo_flush_o = flush_i;
        grant_o      = grant;
        grant_vld_o  = grant_vld;
        locked_o     = (state == ARB_LOCK);
    end

endmodule

// File: tb/tb_fifo_anyread_wr_arb.sv
// Directed plus random checks of the write-port arbiter against a queue-free reference model.
module tb_fifo_anyread_wr_arb;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 flush;
    logic [3:0]           req_valid;
    logic [3:0][2:0]      req_cnt;
    logic [3:0][3:0][7:0] req_data;
    logic [3:0]           req_last;
    logic [3:0]           req_ready;
    logic [2:0]           fifo_write;
    logic [3:0][7:0]      fifo_data;
    logic                 fifo_flush;
    logic                 fifo_ready;
    logic [1:0]           grant;
    logic                 grant_vld;
    logic                 locked;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model: is a packet open, who owns it, who has first priority
    bit m_lock;
    int m_owner;
    int m_ptr;

    logic [3:0] obs_ready;
    logic [2:0] obs_write;
    logic [1:0] obs_grant;
    logic       obs_flush;

    fifo_anyread_wr_arb dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .flush_i      (flush),
        .req_valid_i  (req_valid),
        .req_cnt_i    (req_cnt),
        .req_data_i   (req_data),
        .req_last_i   (req_last),
        .req_ready_o  (req_ready),
        .fifo_write_o (fifo_write),
        .fifo_data_o  (fifo_data),
        .fifo_flush_o (fifo_flush),
        .fifo_ready_i (fifo_ready),
        .grant_o      (grant),
        .grant_vld_o  (grant_vld),
        .locked_o     (locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lock  = 0;
        m_owner = 0;
        m_ptr   = 0;
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    // One clock: check combinational outputs at the falling edge, advance the model on the rising edge.
    task automatic cycle();
        int         g;
        bit         gv;
        bit         acc;
        logic [3:0] e_rdy;
        logic [2:0] e_wr;
        logic [31:0] e_dat;
        @(negedge clk);
        g  = 0;
        gv = 0;
        if (m_lock) begin
            g  = m_owner;
            gv = req_valid[2'(g)];
        end else begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (!gv && req_valid[2'(i)]) begin
                    g  = i;
                    gv = 1;
                end
            end
        end
        acc   = gv && fifo_ready && !flush;
        e_rdy = acc ? 4'(1 << g) : 4'b0;
        e_wr  = acc ? ((req_cnt[2'(g)] > 3'd4) ? 3'd4 : req_cnt[2'(g)]) : 3'd0;
        e_dat = acc ? req_data[2'(g)] : 32'h0;
        chk("grant_vld", grant_vld, gv);
        if (gv) chk("grant", grant, g);
        chk("req_ready", req_ready, e_rdy);
        chk("fifo_write", fifo_write, e_wr);
        chk("fifo_data", fifo_data, e_dat);
        chk("fifo_flush", fifo_flush, flush);
        chk("locked", locked, m_lock);
        obs_ready = req_ready;
        obs_write = fifo_write;
        obs_grant = grant;
        obs_flush = fifo_flush;
        @(posedge clk);
        if (flush) begin
            model_reset();
        end else if (acc) begin
            if (req_last[2'(g)]) begin
                m_lock = 0;
                m_ptr  = (g + 1) % 4;
            end else begin
                m_lock  = 1;
                m_owner = g;
            end
        end
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < 4; i++) req_data[i] = 32'($urandom);
    endtask

    initial begin
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int pkt_cnt[3]   = '{2, 3, 1};

        // reset state
        rstn = 1'b0; flush = 1'b0; req_valid = '0; req_cnt = '0;
        req_data = '0; req_last = '0; fifo_ready = 1'b0;
        model_reset();
        #2;
        chk("rst_ready", req_ready, 4'b0);
        chk("rst_write", fifo_write, 3'd0);
        chk("rst_data", fifo_data, 32'h0);
        chk("rst_flush", fifo_flush, 1'b0);
        chk("rst_gvld", grant_vld, 1'b0);
        chk("rst_grant", grant, 2'd0);
        chk("rst_locked", locked, 1'b0);
        #10 rstn = 1'b1;
        @(posedge clk); #1;

        // fairness: everyone valid with single-beat packets
        req_valid = 4'hF; req_last = 4'hF; fifo_ready = 1'b1;
        for (int i = 0; i < 4; i++) req_cnt[i] = 3'd4;
        for (int n = 0; n < 5; n++) begin
            rand_data();
            cycle();
            chk("fair_order", onehot_idx(obs_ready), exp_order[n]);
            chk("fair_write", obs_write, 3'd4);
        end

        // packet lock: src1 holds the port for three beats
        req_valid = 4'b0111; req_last = 4'b0101;
        for (int n = 0; n < 3; n++) begin
            rand_data();
            req_cnt[1] = 3'(pkt_cnt[n]);
            req_last[1] = (n == 2);
            cycle();
            chk("lock_ready", obs_ready, 4'b0010);
            chk("lock_write", obs_write, 3'(pkt_cnt[n]));
        end
        req_last = 4'b0;
        cycle();
        chk("lock_next_grant", obs_grant, 2'd2);

        // backpressure mid-packet of src2 (first beat taken just above)
        req_valid = 4'hF;
        fifo_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            rand_data();
            cycle();
            chk("bp_ready", obs_ready, 4'b0);
            chk("bp_write", obs_write, 3'd0);
            chk("bp_locked", locked, 1'b1);
        end
        fifo_ready = 1'b1; req_last = 4'hF; req_cnt[2] = 3'd3;
        cycle();
        chk("bp_resume", obs_ready, 4'b0100);

        // count clamp and zero-count closing beat on src3
        req_valid = 4'b1000; req_last = 4'b0; req_cnt[3] = 3'd7;
        rand_data();
        cycle();
        chk("clamp_write", obs_write, 3'd4);
        req_cnt[3] = 3'd0; req_last = 4'b1000;
        cycle();
        chk("zero_write", obs_write, 3'd0);
        chk("zero_ready", obs_ready, 4'b1000);
        chk("zero_idle", locked, 1'b0);

        // flush while src3 holds the lock
        req_last = 4'b0; req_cnt[3] = 3'd2;
        cycle();
        req_valid = 4'hF; flush = 1'b1;
        cycle();
        chk("flush_out", obs_flush, 1'b1);
        chk("flush_noacc", obs_ready, 4'b0);
        flush = 1'b0;
        cycle();
        chk("flush_restart", obs_grant, 2'd0);

        // asynchronous reset in the middle of a locked packet
        req_valid = 4'b0100; req_last = 4'b0;
        cycle();
        chk("prerst_locked", locked, 1'b1);
        #1 rstn = 1'b0;
        #1;
        chk("async_rst_locked", locked, 1'b0);
        model_reset();
        req_valid = 4'hF;
        #1 rstn = 1'b1;
        cycle();
        chk("rst_restart", obs_grant, 2'd0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            req_valid  = 4'($urandom);
            req_last   = 4'($urandom);
            for (int i = 0; i < 4; i++) req_cnt[i] = 3'($urandom_range(0, 7));
            rand_data();
            fifo_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_anyread_wr_arb.md
Name: fifo_anyread_wr_arb

Overview:
Shares the single variable-width write port of the team's any-count FIFO among NUM_REQ packet sources. Round-robin arbitration at packet granularity: once a source wins, it keeps the port until its beat with last is accepted. Sits directly in front of the FIFO write side. The block drives the FIFO's word count, data and flush, and consumes the FIFO's ready.

Parameters:
NUM_REQ, 4, number of requesting sources (>=2)
WORD_WIDTH, 8, bits per word
WORD_CNT_PER_WRITE, 4, max words per beat; must equal the FIFO's value
WRITE_WIDTH, $clog2(WORD_CNT_PER_WRITE+1), width of a word-count field
IDX_WIDTH, $clog2(NUM_REQ), width of a source index

Ports:
clk_i  in  1  clock, rising edge
rstn_i  in  1  asynchronous active-low reset
flush_i  in  1  synchronous flush of arbiter state and FIFO
req_valid_i  in  NUM_REQ  source i offers a beat
req_cnt_i  in  NUM_REQ x WRITE_WIDTH  words in source i beat (0..WORD_CNT_PER_WRITE)
req_data_i  in  NUM_REQ x WORD_CNT_PER_WRITE x WORD_WIDTH  beat words, word 0 first
req_last_i  in  NUM_REQ  beat is last of packet
req_ready_o  out  NUM_REQ  beat of source i accepted this cycle
fifo_write_o  out  WRITE_WIDTH  to FIFO write_i
fifo_data_o  out  WORD_CNT_PER_WRITE x WORD_WIDTH  to FIFO data_i
fifo_flush_o  out  1  to FIFO flush_i
fifo_ready_i  in  1  from FIFO ready_o
grant_o  out  IDX_WIDTH  current winner (valid when grant_vld_o)
grant_vld_o  out  1  some source currently granted
locked_o  out  1  mid-packet lock held

Behaviour:
- States: IDLE, LOCK. Registers: state, owner (IDX_WIDTH), rr_ptr (IDX_WIDTH).
- Reset (async, rstn_i=0): state=IDLE, owner=0, rr_ptr=0. All outputs 0 while in reset with no valid inputs.
- IDLE grant: the first i with req_valid_i[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ. The search is combinational.
- LOCK grant: owner only. Other sources get req_ready_o=0 regardless of valid.
- Grant is valid only if the granted source's req_valid_i=1.
- Acceptance: accept = grant_vld_o & fifo_ready_i & ~flush_i. req_ready_o[grant] = accept. All other ready bits = 0.
- fifo_write_o = accept ? min(req_cnt_i[grant], WORD_CNT_PER_WRITE) : 0. Counts above WORD_CNT_PER_WRITE are clamped.
- fifo_data_o = req_data_i[grant] when accept, else 0.
- Zero-latency (combinational) path from request to FIFO. State updates on the next edge.
- A beat with cnt=0 is accepted normally and writes nothing. It may carry last to close a packet.
- The FIFO's ready guarantees a full beat of credit, so an accepted beat is always written in full. No partial writes are produced.
- IDLE, accept & ~last: go to LOCK, owner<=grant.
- IDLE, accept & last: stay IDLE, rr_ptr<=grant+1 (wraps NUM_REQ-1 -> 0).
- IDLE, no accept: no state change. The combinational winner may change between cycles.
- LOCK, accept & last: go to IDLE, rr_ptr<=owner+1.
- LOCK, otherwise: hold. Owner valid=0 mid-packet keeps the lock (no preemption).
- Non-power-of-2 NUM_REQ: rr_ptr and index wrap explicitly modulo NUM_REQ.
- flush_i=1: fifo_flush_o=1 in the same cycle, no acceptance. Next state IDLE, owner=0, rr_ptr=0.
- flush_i while LOCK: the partial packet is dropped by the FIFO flush. The source must restart the packet.
- grant_o/grant_vld_o reflect the combinational grant. locked_o = (state==LOCK).
- The block does not observe the FIFO's read side.

Decomposition:
- Package fifo_anyread_pkg: state enum arb_state_e {ARB_IDLE, ARB_LOCK}; a function clamp_cnt for the count clamp.
- Sub-module rr_pick: combinational round-robin picker. Inputs req vector and start pointer; outputs idx and found. Parameterised by NUM_REQ.
- Top module holds the FSM, registers and output muxes.

Test Plan:
- Reset mid-LOCK: rstn_i low asynchronously between edges -> locked_o=0 immediately, grant restarts from source 0 after release.
- Fairness: all 4 sources valid, 1-beat packets (last=1, cnt=4), fifo_ready_i=1 -> accept order 0,1,2,3,0; each fifo_write_o=4.
- Packet lock: src1 sends 3 beats (cnt 2,3,1, last on 3rd) while src0/src2 are valid -> only req_ready_o[1] pulses for 3 cycles; next grant is 2.
- Backpressure: fifo_ready_i=0 for 5 cycles mid-packet -> fifo_write_o=0, no ready pulses, lock held; resumes with the same owner.
- Count clamp and zero beat: req_cnt_i=7 (WRITE_WIDTH=3) -> fifo_write_o=4; a cnt=0, last=1 beat -> fifo_write_o=0, ready pulses, state returns to IDLE.
- Flush: flush_i during LOCK of src3 -> fifo_flush_o=1, no accept that cycle. Next cycle state is IDLE with rr_ptr=0, so src0 wins if valid.
